// File: rtl/ab_input_conditioner.sv
// rtl/ab_input_conditioner.sv - two-channel synchroniser and debouncer for A/B inputs
// Optional glitch counter output enabled by defining AB_GLITCH_CNT_EN.
module ab_input_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a_raw,
    input  logic       b_raw,
    output logic       a_out,
    output logic       b_out,
    output logic       change,
    output logic       stable
`ifdef AB_GLITCH_CNT_EN
    ,
    output logic [7:0] glitch_cnt
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        CHECK = 1'b1
    } state_t;

    // The IDLE->CHECK edge already counts as the first stable cycle, so the
    // update fires when the counter reaches DEBOUNCE_CYCLES-1 in CHECK.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q [2];
    state_t                 state_q [2];
    state_t                 state_d [2];
    logic [CNT_W-1:0]       cnt_q [2];
    logic [CNT_W-1:0]       cnt_d [2];
    logic [1:0]             out_q;
    logic [1:0]             out_d;
    logic [1:0]             raw;
    logic [1:0]             s;
    logic [1:0]             upd;
    logic [1:0]             abort;

    assign raw = {b_raw, a_raw};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            s[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            out_q  <= '0;
            change <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            out_q  <= out_d;
            change <= |upd;
        end
    end

    always_comb begin
        out_d = out_q;
        upd   = '0;
        abort = '0;
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                IDLE: begin
                    if (s[i] != out_q[i]) begin
                        // With a one-cycle debounce the first mismatch is already enough.
                        if (DEBOUNCE_CYCLES == 1) begin
                            out_d[i] = s[i];
                            upd[i]   = 1'b1;
                            cnt_d[i] = '0;
                        end else begin
                            state_d[i] = CHECK;
                            cnt_d[i]   = CNT_ONE;
                        end
                    end else begin
                        cnt_d[i] = '0;
                    end
                end
                CHECK: begin
                    if (s[i] == out_q[i]) begin
                        abort[i]   = 1'b1;
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] >= CNT_LAST) begin
                        out_d[i]   = s[i];
                        upd[i]     = 1'b1;
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    assign a_out  = out_q[0];
    assign b_out  = out_q[1];
    assign stable = (state_q[0] == IDLE) && (state_q[1] == IDLE);

`ifdef AB_GLITCH_CNT_EN
    logic [1:0] abort_sum;
    logic [8:0] glitch_sum;
    logic [7:0] glitch_q;

    assign abort_sum  = {1'b0, abort[0]} + {1'b0, abort[1]};
    assign glitch_sum = {1'b0, glitch_q} + {7'b0, abort_sum};

    // Bit 8 of the widened sum flags overflow; clamp at 255 instead of wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            glitch_q <= '0;
        end else begin
            glitch_q <= glitch_sum[8] ? 8'hFF : glitch_sum[7:0];
        end
    end

    assign glitch_cnt = glitch_q;
`else
    logic unused_abort;
    assign unused_abort = ^abort;
`endif

endmodule
